// File: rtl/cdc_arb_pkg.sv
// Shared types and elaboration helpers for the CDC transfer arbiter and its round-robin picker.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cdc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LAUNCH   = 2'd1,
        WAIT_ACK = 2'd2
    } arb_state_t;

    // Ceiling log2 for elaboration-time width sizing; clog2(1) = 0.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Width of a requester index; never narrower than one bit.
    function automatic int grant_w(input int n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/cdc_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after i_ptr, wrapping modulo N.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides whether the pick is consumed.
// Ports:
//   i_valid [N-1:0]  per-requester valid
//   i_ptr   [W-1:0]  highest-priority index this cycle
//   o_grant [N-1:0]  one-hot winner (all zero when nothing is valid)
//   o_idx   [W-1:0]  binary index of the winner (0 when nothing is valid)
//   o_any            at least one requester is valid
module cdc_rr_pick
    import cdc_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = grant_w(N)
) (
    input  logic [N-1:0] i_valid,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    always_comb begin
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        // Walk outward from the pointer; the first hit wins and masks the rest.
        for (int k = 0; k < N; k++) begin
            j = (int'(i_ptr) + k) % N;
            if (!o_any && i_valid[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = W'(j);
            end
        end
    end

endmodule

// File: rtl/cdc_xfer_arbiter.sv
// Round-robin scheduler sharing one toggle-handshake CDC channel among NUM_REQ requesters.
// Latency: grant cycle T0 -> o_xfer_data valid T0+1 -> o_xfer_req toggles T0+2; ack sync adds ACK_STAGES cycles.
// Backpressure: o_req_ready is held low until the previous toggle has been acknowledged (channel quiescent).
// Optional build macro: CDC_ARB_TIMEOUT_EN enables the WAIT_ACK watchdog and o_timeout_err pulse.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_req_valid/_data     per-requester valid and flattened words (requester i at [i*DATA_WIDTH +: DATA_WIDTH])
//   o_req_ready           one-hot accept, high only in the grant cycle
//   o_grant_id            index of the last granted requester
//   o_xfer_data/_req      registered word and request toggle towards the destination domain
//   i_xfer_ack_async      ack toggle from the destination domain
//   o_busy                channel cannot take a new grant
//   o_timeout_err         one-cycle watchdog pulse (constant 0 without CDC_ARB_TIMEOUT_EN)
module cdc_xfer_arbiter
    import cdc_arb_pkg::*;
#(
    parameter int  NUM_REQ        = 4,
    parameter int  DATA_WIDTH     = 8,
    parameter int  ACK_STAGES     = 2,
    parameter int  TIMEOUT_CYCLES = 255,
    localparam int GRANT_W        = grant_w(NUM_REQ)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [GRANT_W-1:0]            o_grant_id,
    output logic [DATA_WIDTH-1:0]         o_xfer_data,
    output logic                          o_xfer_req,
    input  logic                          i_xfer_ack_async,
    output logic                          o_busy,
    output logic                          o_timeout_err
);

    if (NUM_REQ < 2 || ACK_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("cdc_xfer_arbiter: parameter out of range");
    end

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    logic [ACK_STAGES-1:0]   r_ack_sync;
    logic                    r_xfer_req;
    logic [DATA_WIDTH-1:0]   r_xfer_data;
    logic [GRANT_W-1:0]      r_grant_id;
    logic [GRANT_W-1:0]      r_ptr;

    logic                    w_ack_s;
    logic                    w_quiescent;
    logic [NUM_REQ-1:0]      w_pick_onehot;
    logic [GRANT_W-1:0]      w_pick_idx;
    logic                    w_pick_any;
    logic                    w_grant;
    logic [DATA_WIDTH-1:0]   w_word;
    logic                    w_timeout;

    // Ack synchronizer: bit 0 samples the asynchronous toggle, the top bit is the safe copy.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[ACK_STAGES-2:0], i_xfer_ack_async};
        end
    end

    assign w_ack_s     = r_ack_sync[ACK_STAGES-1];
    // Equal toggles mean every launched word has been acknowledged (or no spurious ack is pending).
    assign w_quiescent = (w_ack_s == r_xfer_req);

    cdc_rr_pick #(
        .N (NUM_REQ),
        .W (GRANT_W)
    ) u_pick (
        .i_valid (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_pick_onehot),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    assign w_grant = (r_state == IDLE) && w_quiescent && w_pick_any;
    assign w_word  = i_req_data[int'(w_pick_idx)*DATA_WIDTH +: DATA_WIDTH];

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and combinational outputs
    always_comb begin
        w_state_nxt = r_state;
        o_req_ready = '0;
        o_busy      = (r_state != IDLE) || !w_quiescent;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    o_req_ready = w_pick_onehot;
                    w_state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                w_state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                // A watchdog expiry drops the word; the late ack later restores quiescence.
                if (w_quiescent || w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: word capture at grant, toggle one cycle later so data is settled first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_xfer_data <= '0;
            r_grant_id  <= '0;
            r_ptr       <= '0;
            r_xfer_req  <= 1'b0;
        end else begin
            if (w_grant) begin
                r_xfer_data <= w_word;
                r_grant_id  <= w_pick_idx;
                r_ptr       <= (w_pick_idx == GRANT_W'(NUM_REQ - 1)) ? '0 : w_pick_idx + GRANT_W'(1);
            end
            if (r_state == LAUNCH) begin
                r_xfer_req <= ~r_xfer_req;
            end
        end
    end

`ifdef CDC_ARB_TIMEOUT_EN
    localparam int WDOG_W = clog2(TIMEOUT_CYCLES + 1);

    logic [WDOG_W-1:0] r_wdog;
    logic              r_timeout_err;

    // The counter holds the number of WAIT_ACK cycles already elapsed, so expiry fires in the
    // TIMEOUT_CYCLES-th cycle and the pulse appears together with the return to IDLE.
    assign w_timeout = (r_state == WAIT_ACK) && !w_quiescent &&
                       (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout;
            if (r_state == LAUNCH) begin
                r_wdog <= '0;
            end else if (r_state == WAIT_ACK) begin
                r_wdog <= r_wdog + WDOG_W'(1);
            end
        end
    end

    assign o_timeout_err = r_timeout_err;
`else
    assign w_timeout     = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    assign o_grant_id  = r_grant_id;
    assign o_xfer_data = r_xfer_data;
    assign o_xfer_req  = r_xfer_req;

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// Directed bench for cdc_xfer_arbiter (NUM_REQ=4, DATA_WIDTH=8, ACK_STAGES=2, TIMEOUT_CYCLES=16).
// Expected transfers are queued at grant time and popped when the request toggle is seen.
module tb_cdc_xfer_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] word;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    req_ready;
    logic [1:0]       grant_id;
    logic [DW-1:0]    xfer_data;
    logic             xfer_req;
    logic             ack;
    logic             busy;
    logic             timeout_err;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    logic last_req;
    int   order[6] = '{0, 1, 2, 3, 0, 1};

    always #5 clk = ~clk;

    cdc_xfer_arbiter #(
        .NUM_REQ        (NR),
        .DATA_WIDTH     (DW),
        .ACK_STAGES     (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_req_valid      (req_valid),
        .i_req_data       (req_data),
        .o_req_ready      (req_ready),
        .o_grant_id       (grant_id),
        .o_xfer_data      (xfer_data),
        .o_xfer_req       (xfer_req),
        .i_xfer_ack_async (ack),
        .o_busy           (busy),
        .o_timeout_err    (timeout_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int id);
        exp_t e;
        e.id   = 2'(id);
        e.word = req_data[id*DW +: DW];
        sb.push_back(e);
    endtask

    // Wait (bounded) for the request toggle, then compare against the oldest queued grant.
    task automatic wait_xfer(input string tag);
        int   n;
        logic exp_r;
        exp_t e;
        n     = 0;
        exp_r = ~last_req;
        while (xfer_req === last_req && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_toggle"}, 32'(xfer_req), 32'(exp_r));
        last_req = xfer_req;
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_grant_id"}, 32'(grant_id), 32'(e.id));
            check({tag, "_xfer_data"}, 32'(xfer_data), 32'(e.word));
        end
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach summary");
        $fatal(1, "global timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        ack       = 1'b0;
        last_req  = 1'b0;

        // 1. reset state
        tick();
        tick();
        check("rst_xfer_req", 32'(xfer_req), 32'd0);
        check("rst_xfer_data", 32'(xfer_data), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        tick();

        // 2. single request from requester 2
        req_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
        req_valid = 4'b0100;
        #1;
        check("t2_ready", 32'(req_ready), 32'h4);
        check("t2_busy_idle", 32'(busy), 32'd0);
        push_exp(2);
        tick();
        req_valid = '0;
        #1;
        check("t2_ready_once", 32'(req_ready), 32'd0);
        check("t2_gid_launch", 32'(grant_id), 32'd2);
        check("t2_data_launch", 32'(xfer_data), 32'hA5);
        check("t2_req_not_yet", 32'(xfer_req), 32'd0);
        check("t2_busy_launch", 32'(busy), 32'd1);
        tick();
        check("t2_req_t0p2", 32'(xfer_req), 32'd1);
        wait_xfer("t2");
        ack = 1'b1;
        tick();
        check("t2_busy_a0", 32'(busy), 32'd1);
        tick();
        check("t2_busy_a1", 32'(busy), 32'd1);
        tick();
        check("t2_busy_a2", 32'(busy), 32'd0);

        // Reset to bring the pointer back to requester 0 (destination resets with it).
        rst = 1'b1;
        ack = 1'b0;
        tick();
        rst      = 1'b0;
        last_req = 1'b0;

        // 3. all requesters valid: strict rotation
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NR; i++) begin
                req_data[i*DW +: DW] = 8'($urandom);
            end
            #1;
            check("t3_ready", 32'(req_ready), 32'(1) << order[k]);
            push_exp(order[k]);
            tick();
            wait_xfer("t3");
            tick();
            ack = ~ack;
            wait_idle("t3_idle");
        end

        // 4. reset during WAIT_ACK
        #1;
        check("t4_ready_ptr2", 32'(req_ready), 32'h4);
        push_exp(2);
        tick();
        wait_xfer("t4_pre");
        rst = 1'b1;
        ack = 1'b0;
        tick();
        check("t4_xfer_req", 32'(xfer_req), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_grant_id", 32'(grant_id), 32'd0);
        check("t4_xfer_data", 32'(xfer_data), 32'd0);
        rst      = 1'b0;
        last_req = 1'b0;
        #1;
        check("t4_ptr0_ready", 32'(req_ready), 32'h1);
        push_exp(0);
        tick();
        wait_xfer("t4_post");
        ack = 1'b1;
        wait_idle("t4_idle");

        // 5. spurious ack toggle while IDLE
        req_valid = '0;
        ack       = 1'b0;
        tick();
        tick();
        req_valid = 4'b0001;
        #1;
        check("t5_busy_mismatch", 32'(busy), 32'd1);
        check("t5_ready_blocked", 32'(req_ready), 32'd0);
        tick();
        check("t5_ready_blocked2", 32'(req_ready), 32'd0);
        check("t5_timeout_err", 32'(timeout_err), 32'd0);
        ack = 1'b1;
        tick();
        check("t5_ready_a0", 32'(req_ready), 32'd0);
        tick();
        check("t5_ready_a1", 32'(req_ready), 32'h1);
        push_exp(0);
        tick();
        req_valid = '0;
        wait_xfer("t5");
        ack = 1'b0;
        wait_idle("t5_idle");

`ifdef CDC_ARB_TIMEOUT_EN
        // 6. watchdog expiry with no ack, then a late ack
        req_valid = 4'b0010;
        #1;
        check("t6_ready", 32'(req_ready), 32'h2);
        push_exp(1);
        tick();
        req_valid = '0;
        wait_xfer("t6");
        repeat (15) tick();
        check("t6_no_err_early", 32'(timeout_err), 32'd0);
        tick();
        check("t6_err_pulse", 32'(timeout_err), 32'd1);
        check("t6_busy_at_err", 32'(busy), 32'd1);
        req_valid = 4'b0001;
        tick();
        check("t6_err_single", 32'(timeout_err), 32'd0);
        check("t6_busy_blocked", 32'(busy), 32'd1);
        check("t6_ready_blocked", 32'(req_ready), 32'd0);
        req_valid = '0;
        ack       = 1'b1;
        wait_idle("t6_late_ack");
        check("t6_req_held", 32'(xfer_req), 32'd1);
        check("t6_gid_held", 32'(grant_id), 32'd1);
        check("t6_no_err", 32'(timeout_err), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
